factorial_ctrl: RTL and testbench
=================================

Name: factorial_ctrl

Overview:
- Moore FSM that sequences the factorial datapath: repeatedly issues multiply (x0 <= x0*x1) then decrement (x1 <= x1 - x2) until the datapath flags x1 == x2 via z.
- Adds a start/done/ack handshake, abort, an iteration guard with error reporting, and iteration/cycle counters for status.
- Sits between the system-level sequencer and the datapath; it drives every datapath control input.

Parameters:
- MAX_ITER, 128, iteration limit; reaching it with z still low → ERR state.
- ITER_W, 8, width of iter_count; must satisfy 2^ITER_W > MAX_ITER.
- CYC_W, 16, width of cycle_count; saturates at all-ones.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin computation; sampled only in IDLE
- ack  in  1  acknowledge; leaves DONE/ERR
- abort  in  1  cancel an in-progress computation
- z  in  1  datapath flag, x1 == x2
- a_sel  out  2  datapath A operand select (00 x0, 01 x1, 10 x2)
- b_sel  out  2  datapath B operand select (same encoding)
- op_sel  out  1  0 multiply, 1 subtract
- w_sel  out  1  0 write x0, 1 write x1
- w_en  out  1  datapath write enable
- busy  out  1  high in CHECK/MUL/DEC
- done  out  1  high in DONE
- err  out  1  high in ERR
- iter_count  out  ITER_W  completed multiply/decrement pairs this run
- cycle_count  out  CYC_W  cycles spent in busy states this run

Behaviour:
- States: IDLE, CHECK, MUL, DEC, DONE, ERR. On rst: IDLE; all outputs 0; counters 0.
- Default decode (IDLE, CHECK, DONE, ERR): a_sel=00, b_sel=00, op_sel=0, w_sel=0, w_en=0.
- IDLE:
  - start=1 → CHECK; iter_count and cycle_count cleared to 0 on the same edge.
  - start=0 → stay.
- CHECK:
  - z=1 → DONE (z has priority over the limit).
  - else iter_count==MAX_ITER → ERR.
  - else → MUL.
- MUL: a_sel=00, b_sel=01, op_sel=0, w_sel=0, w_en=1 → DEC.
- DEC:
  - a_sel=01, b_sel=10, op_sel=1, w_sel=1, w_en=1 → CHECK.
  - iter_count increments on the exit edge.
- DONE / ERR:
  - Hold done (resp. err) high; iter_count and cycle_count hold.
  - ack=1 → IDLE. start is ignored in these states.
- Counters:
  - cycle_count increments on every edge taken while in CHECK, MUL or DEC; saturates, no wrap.
  - iter_count never exceeds MAX_ITER.
- abort:
  - In CHECK/MUL/DEC: next state IDLE.
  - w_en is gated combinationally (w_en = decode & ~abort), so no datapath write occurs in the abort cycle.
  - Counters hold their values; done/err are not asserted.
  - Ignored in IDLE/DONE/ERR.
- Simultaneous events:
  - abort beats any CHECK decision.
  - ack and start together in DONE → IDLE only; a fresh start is needed afterwards.
- Reset mid-run: immediate return to IDLE with all outputs 0, regardless of state.
- Latency: each iteration takes 3 cycles (CHECK, MUL, DEC). For N iterations, done rises 3N+2 cycles after the start-sampling edge, and cycle_count = 3N+1.
- The controller never observes Result; 32-bit product overflow is the datapath's concern.
- The datapath is re-initialised only by rst, so a second run without rst terminates immediately: N=0, done after 2 cycles.

Test Plan:
1. rst, then start pulse with the real datapath (x1=100) → 99 iterations; done rises 299 cycles after start; iter_count=99, cycle_count=298, Result register x0 = 100! mod 2^32 = 0.
2. Stub z that goes high after the 4th DEC → MUL/DEC pairs alternate with correct selects (MUL: 00/01/0/0/1, DEC: 01/10/1/1/1); done after 14 cycles; iter_count=4, cycle_count=13.
3. MAX_ITER=10, z held 0 → err=1 after 32 cycles; iter_count=10; ack → IDLE with err=0.
4. abort asserted in the first MUL cycle of iteration 3 → w_en=0 in that cycle; IDLE next cycle; iter_count=2; done=0, err=0.
5. rst asserted asynchronously mid-DEC → all outputs 0 immediately, state IDLE; start ignored until rst is released.
6. In DONE, drive start=1 with ack=0 for 5 cycles → done stays 1, no w_en; then start=ack=1 → IDLE, no new run; later start → done after 2 cycles with N=0.

Source files
------------

// File: rtl/factorial_ctrl_if.sv
// Handshake and datapath-control bundle for factorial_ctrl.
// master: the controller itself; slave: the sequencer/datapath side.
interface factorial_ctrl_if #(
  parameter int ITER_W = 8,
  parameter int CYC_W  = 16
);
  logic              start;
  logic              ack;
  logic              abort;
  logic              z;
  logic [1:0]        a_sel;
  logic [1:0]        b_sel;
  logic              op_sel;
  logic              w_sel;
  logic              w_en;
  logic              busy;
  logic              done;
  logic              err;
  logic [ITER_W-1:0] iter_count;
  logic [CYC_W-1:0]  cycle_count;

  modport master (
    input  start, ack, abort, z,
    output a_sel, b_sel, op_sel, w_sel, w_en,
    output busy, done, err, iter_count, cycle_count
  );

  modport slave (
    output start, ack, abort, z,
    input  a_sel, b_sel, op_sel, w_sel, w_en,
    input  busy, done, err, iter_count, cycle_count
  );
endinterface

// File: rtl/factorial_ctrl.sv
// Moore controller for the factorial datapath: alternates multiply
// (x0 <= x0*x1) and decrement (x1 <= x1-x2) until z, with a
// start/done/ack handshake, abort, an iteration guard and status counters.
module factorial_ctrl #(
  parameter int MAX_ITER = 128,
  parameter int ITER_W   = 8,
  parameter int CYC_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  factorial_ctrl_if.master   bus
);

  typedef enum logic [2:0] {IDLE, CHECK, MUL, DEC, DONE, ERR} state_t;

  typedef struct packed {
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic       op_sel;
    logic       w_sel;
    logic       w_en;
    logic       busy;
    logic       done;
    logic       err;
  } ctl_t;

  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);
  localparam logic [CYC_W-1:0]  CYC_SAT    = '1;

  state_t            state;
  state_t            state_nxt;
  ctl_t              ctl;
  logic [ITER_W-1:0] iter_count;
  logic [CYC_W-1:0]  cycle_count;
  logic              busy_state;

  // Output word for a given state; everything not listed stays at the
  // default decode (all zero).
  function automatic ctl_t decode(input state_t s);
    ctl_t c;
    // NOTE: assigning a full default before the case keeps every field
    // driven on every path, so no latch can be inferred.
    c = '0;
    case (s)
      CHECK: c.busy = 1'b1;
      MUL: begin
        c.b_sel = 2'b01;
        c.w_en  = 1'b1;
        c.busy  = 1'b1;
      end
      DEC: begin
        c.a_sel  = 2'b01;
        c.b_sel  = 2'b10;
        c.op_sel = 1'b1;
        c.w_sel  = 1'b1;
        c.w_en   = 1'b1;
        c.busy   = 1'b1;
      end
      DONE:    c.done = 1'b1;
      ERR:     c.err  = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  // Transition rules; abort outranks every busy-state decision and z
  // outranks the iteration limit.
  function automatic state_t next_of(input state_t s, input logic start,
                                     input logic ack, input logic abort,
                                     input logic z, input logic at_limit);
    state_t n;
    n = s;
    case (s)
      IDLE:  if (start) n = CHECK;
      CHECK: begin
        if (abort)         n = IDLE;
        else if (z)        n = DONE;
        else if (at_limit) n = ERR;
        else               n = MUL;
      end
      MUL:   n = abort ? IDLE : DEC;
      DEC:   n = abort ? IDLE : CHECK;
      DONE:  if (ack) n = IDLE;
      ERR:   if (ack) n = IDLE;
      default: n = IDLE;
    endcase
    return n;
  endfunction

  assign busy_state = (state == CHECK) || (state == MUL) || (state == DEC);
  assign state_nxt  = next_of(state, bus.start, bus.ack, bus.abort, bus.z,
                              iter_count == ITER_LIMIT);

  // State, registered output word and the two status counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ctl         <= '0;
      iter_count  <= '0;
      cycle_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values regardless of statement order.
      state <= state_nxt;
      ctl   <= decode(state_nxt);
      if (state == IDLE && bus.start) begin
        iter_count  <= '0;
        cycle_count <= '0;
      end else if (busy_state && !bus.abort) begin
        if (cycle_count != CYC_SAT) cycle_count <= cycle_count + 1'b1;
        if (state == DEC && iter_count != ITER_LIMIT)
          iter_count <= iter_count + 1'b1;
      end
    end
  end

  assign bus.a_sel       = ctl.a_sel;
  assign bus.b_sel       = ctl.b_sel;
  assign bus.op_sel      = ctl.op_sel;
  assign bus.w_sel       = ctl.w_sel;
  // Write enable is cut in the same cycle abort is seen, so an aborted
  // MUL/DEC never reaches the datapath registers.
  assign bus.w_en        = ctl.w_en & ~bus.abort;
  assign bus.busy        = ctl.busy;
  assign bus.done        = ctl.done;
  assign bus.err         = ctl.err;
  assign bus.iter_count  = iter_count;
  assign bus.cycle_count = cycle_count;

endmodule

// File: tb/tb_factorial_ctrl.sv
// Self-checking bench for factorial_ctrl: a behavioural datapath, a stub z
// source, and a second instance with a small iteration limit.
module tb_factorial_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  factorial_ctrl_if #(.ITER_W(8), .CYC_W(16)) bus ();
  factorial_ctrl_if #(.ITER_W(8), .CYC_W(16)) bus_lim ();

  factorial_ctrl #(.MAX_ITER(128), .ITER_W(8), .CYC_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  factorial_ctrl #(.MAX_ITER(10), .ITER_W(8), .CYC_W(16)) dut_lim (
    .clk(clk), .rst(rst), .bus(bus_lim)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Control words {a_sel,b_sel,op_sel,w_sel,w_en,busy,done,err}.
  localparam logic [9:0] W_IDLE  = 10'b00_00_0_0_0_0_0_0;
  localparam logic [9:0] W_CHECK = 10'b00_00_0_0_0_1_0_0;
  localparam logic [9:0] W_MUL   = 10'b00_01_0_0_1_1_0_0;
  localparam logic [9:0] W_DEC   = 10'b01_10_1_1_1_1_0_0;
  localparam logic [9:0] W_DONE  = 10'b00_00_0_0_0_0_1_0;
  localparam logic [9:0] W_ERR   = 10'b00_00_0_0_0_0_0_1;

  logic [9:0] word, word_lim;
  assign word     = {bus.a_sel, bus.b_sel, bus.op_sel, bus.w_sel, bus.w_en,
                     bus.busy, bus.done, bus.err};
  assign word_lim = {bus_lim.a_sel, bus_lim.b_sel, bus_lim.op_sel,
                     bus_lim.w_sel, bus_lim.w_en, bus_lim.busy,
                     bus_lim.done, bus_lim.err};

  // Behavioural datapath: x0 <= x0*x1 / x1 <= x1-x2, reinitialised by rst.
  logic [31:0] x0, x1, x2;

  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] r0,
                                       input logic [31:0] r1, input logic [31:0] r2);
    return (s == 2'b00) ? r0 : (s == 2'b01) ? r1 : r2;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      x0 <= 32'd1;
      x1 <= 32'd100;
      x2 <= 32'd1;
    end else if (bus.w_en) begin
      if (bus.w_sel)
        x1 <= bus.op_sel ? pick(bus.a_sel, x0, x1, x2) - pick(bus.b_sel, x0, x1, x2)
                         : pick(bus.a_sel, x0, x1, x2) * pick(bus.b_sel, x0, x1, x2);
      else
        x0 <= bus.op_sel ? pick(bus.a_sel, x0, x1, x2) - pick(bus.b_sel, x0, x1, x2)
                         : pick(bus.a_sel, x0, x1, x2) * pick(bus.b_sel, x0, x1, x2);
    end
  end

  // Stub z: rises once stub_n decrement writes have happened in this run.
  logic use_stub = 1'b0;
  logic stub_clr = 1'b0;
  int   stub_n   = 0;
  int   dec_cnt  = 0;

  always @(posedge clk) begin
    if (stub_clr)                 dec_cnt <= 0;
    else if (bus.w_en && bus.w_sel) dec_cnt <= dec_cnt + 1;
  end

  assign bus.z     = use_stub ? (dec_cnt >= stub_n) : (x1 == x2);
  assign bus_lim.z = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled on negedges.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected word for cycle p of an N-iteration run; p = 1 is the cycle
  // right after the start-sampling edge. Each iteration is CHECK, MUL, DEC
  // and the final CHECK is followed by DONE at p = 3N+2.
  function automatic logic [9:0] expect_word(input int p, input int n);
    if (p >= 3 * n + 2) return W_DONE;
    case (p % 3)
      1:       return W_CHECK;
      2:       return W_MUL;
      default: return W_DEC;
    endcase
  endfunction

  task automatic start_run();
    bus.start = 1'b1;
    stub_clr  = 1'b1;
    tick();
    bus.start = 1'b0;
    stub_clr  = 1'b0;
  endtask

  // Runs N iterations from IDLE and checks every cycle up to DONE.
  task automatic run_and_check(input int n, input string tag);
    start_run();
    for (int p = 1; p <= 3 * n + 1; p++) begin
      check({tag, " seq"}, 32'(word), 32'(expect_word(p, n)));
      tick();
    end
    check({tag, " done"}, 32'(word), 32'(W_DONE));
    check({tag, " iter"}, 32'(bus.iter_count), 32'(n));
    check({tag, " cyc"},  32'(bus.cycle_count), 32'(3 * n + 1));
  endtask

  task automatic ack_main(input string tag);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check({tag, " ack idle"}, 32'(word), 32'(W_IDLE));
  endtask

  initial begin
    logic [31:0] fact;
    int          n;

    bus.start = 1'b0; bus.ack = 1'b0; bus.abort = 1'b0;
    bus_lim.start = 1'b0; bus_lim.ack = 1'b0; bus_lim.abort = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst word",     32'(word), 32'(W_IDLE));
    check("rst iter",     32'(bus.iter_count), 32'd0);
    check("rst cyc",      32'(bus.cycle_count), 32'd0);
    check("rst lim word", 32'(word_lim), 32'(W_IDLE));
    rst = 1'b0;
    tick();

    // Real datapath from x1=100: 99 iterations, x0 = 100! mod 2^32
    fact = 32'd1;
    for (int i = 2; i <= 100; i++) fact = fact * 32'(i);
    use_stub = 1'b0;
    run_and_check(99, "fact100");
    check("fact100 x0", x0, fact);

    // DONE ignores start; start+ack leaves to IDLE without a new run
    for (int k = 0; k < 5; k++) begin
      bus.start = 1'b1;
      tick();
      check("done hold word", 32'(word), 32'(W_DONE));
      check("done hold iter", 32'(bus.iter_count), 32'd99);
    end
    check("done hold cyc", 32'(bus.cycle_count), 32'd298);
    bus.ack = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    check("start+ack idle", 32'(word), 32'(W_IDLE));
    tick();
    check("no new run", 32'(word), 32'(W_IDLE));
    check("idle iter hold", 32'(bus.iter_count), 32'd99);

    // Second run without rst: datapath already has x1 == x2
    run_and_check(0, "rerun");
    ack_main("rerun");

    // Stub z after the 4th decrement, then random iteration counts
    use_stub = 1'b1;
    stub_n   = 4;
    run_and_check(4, "stub4");
    ack_main("stub4");
    for (int r = 0; r < 6; r++) begin
      n      = int'($urandom_range(0, 15));
      stub_n = n;
      run_and_check(n, "rand");
      ack_main("rand");
    end

    // Abort in the MUL cycle of iteration 3 (p = 8)
    stub_n = 20;
    start_run();
    for (int p = 1; p < 8; p++) tick();
    check("abort pre mul", 32'(word), 32'(W_MUL));
    bus.abort = 1'b1;
    #1;
    check("abort w_en", 32'(bus.w_en), 32'd0);
    tick();
    bus.abort = 1'b0;
    check("abort idle", 32'(word), 32'(W_IDLE));
    check("abort iter", 32'(bus.iter_count), 32'd2);
    check("abort cyc",  32'(bus.cycle_count), 32'd7);

    // Asynchronous reset in the middle of a DEC cycle
    stub_n = 5;
    start_run();
    tick();
    tick();
    check("pre rst dec", 32'(word), 32'(W_DEC));
    #2 rst = 1'b1;
    #1;
    check("async rst word", 32'(word), 32'(W_IDLE));
    check("async rst cyc",  32'(bus.cycle_count), 32'd0);
    @(negedge clk);
    bus.start = 1'b1;
    tick();
    tick();
    check("start in rst", 32'(word), 32'(W_IDLE));
    bus.start = 1'b0;
    rst = 1'b0;
    tick();
    check("post rst idle", 32'(word), 32'(W_IDLE));

    // Iteration limit of 10 with z held low
    bus_lim.start = 1'b1;
    tick();
    bus_lim.start = 1'b0;
    for (int p = 1; p < 31; p++) tick();
    check("lim last check", 32'(word_lim), 32'(W_CHECK));
    check("lim iter at 31", 32'(bus_lim.iter_count), 32'd10);
    tick();
    check("lim err", 32'(word_lim), 32'(W_ERR));
    check("lim iter", 32'(bus_lim.iter_count), 32'd10);
    check("lim cyc",  32'(bus_lim.cycle_count), 32'd31);
    bus_lim.start = 1'b1;
    tick();
    bus_lim.start = 1'b0;
    check("lim err hold", 32'(word_lim), 32'(W_ERR));
    bus_lim.ack = 1'b1;
    tick();
    bus_lim.ack = 1'b0;
    check("lim ack idle", 32'(word_lim), 32'(W_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
